// File: rtl/ber_pkg.sv
// Shared types and constants for the BER test controller and its PRBS16 generator.
// Optional frame-error injection is enabled with the BER_CTRL_INJECT_EN macro.
package ber_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SEND,
    WAIT_RX,
    FINISH
  } state_t;

  // Right-shift Fibonacci taps for x^16+x^14+x^13+x^11+1 (bits 0, 2, 3 and 5).
  localparam logic [15:0] LFSR_TAPS         = 16'h002D;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic prbs_feedback(input logic [15:0] value);
    return ^(value & LFSR_TAPS);
  endfunction

  // Every 8th frame (index 7, 15, ...) is corrupted when injection is built in.
  function automatic logic inject_hit(input logic [15:0] frame_idx);
    return frame_idx[2:0] == 3'b111;
  endfunction

endpackage

// File: rtl/ber_test_ctrl_if.sv
// Channel-side bundle of the BER test controller: transmit handshake, receive
// strobe and the aligned compare pair handed to the BER calculator.
interface ber_test_ctrl_if #(
  parameter int DATA_W = 16
);

  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              cmp_valid;
  logic [DATA_W-1:0] cmp_tx;
  logic [DATA_W-1:0] cmp_rx;

  modport master (
    output tx_valid, tx_data, cmp_valid, cmp_tx, cmp_rx,
    input  tx_ready, rx_valid, rx_data
  );

  modport slave (
    input  tx_valid, tx_data, cmp_valid, cmp_tx, cmp_rx,
    output tx_ready, rx_valid, rx_data
  );

endinterface

// File: rtl/prbs16.sv
// 16-bit Fibonacci PRBS generator; load restarts the sequence from SEED and
// enable advances it by one step.
module prbs16
  import ber_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        enable,
  output logic [15:0] value
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      value <= SEED;
    end else if (enable) begin
      value <= {prbs_feedback(value), value[15:1]};
    end
  end

endmodule

// File: rtl/ber_test_ctrl.sv
// BER test controller: sends PRBS frames, pairs each with its echo for the BER
// calculator and counts frames lost to timeout. BER_CTRL_INJECT_EN adds errors.
module ber_test_ctrl
  import ber_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [15:0] LFSR_SEED   = LFSR_DEFAULT_SEED
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            num_frames,
  ber_test_ctrl_if.master        bus,
  output logic                   ber_clear,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            timeouts
);

  localparam int TMR_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [15:0]       frames_lat;
  logic [15:0]       frame_cnt;
  logic [15:0]       frame_cnt_nxt;
  logic [TMR_W-1:0]  timer;
  logic [DATA_W-1:0] ref_q;
  logic [15:0]       lfsr_q;
  logic [DATA_W-1:0] lfsr_word;
  logic [DATA_W-1:0] tx_word;
  logic              lfsr_load;
  logic              lfsr_step;
  logic              timer_hit;

  assign lfsr_load     = (state == IDLE) && start && (num_frames != 16'd0);
  assign lfsr_step     = (state == SEND) && bus.tx_valid && bus.tx_ready;
  assign lfsr_word     = DATA_W'(lfsr_q);
  assign frame_cnt_nxt = frame_cnt + 16'd1;
  assign timer_hit     = (timer == TMR_LAST);

`ifdef BER_CTRL_INJECT_EN
  // Index of the frame about to be loaded into tx_data: 0 from CLEAR, else the
  // count of frames completed once the current one retires.
  logic [15:0] tx_idx;
  assign tx_idx  = (state == CLEAR) ? 16'd0 : frame_cnt_nxt;
  assign tx_word = lfsr_word ^ DATA_W'(inject_hit(tx_idx));
`else
  assign tx_word = lfsr_word;
`endif

  prbs16 #(
    .SEED (LFSR_SEED)
  ) u_prbs (
    .clk    (clk),
    .reset  (reset),
    .load   (lfsr_load),
    .enable (lfsr_step),
    .value  (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.tx_valid  <= 1'b0;
      bus.tx_data   <= '0;
      bus.cmp_valid <= 1'b0;
      bus.cmp_tx    <= '0;
      bus.cmp_rx    <= '0;
      ber_clear     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeouts      <= '0;
      frames_lat    <= '0;
      frame_cnt     <= '0;
      timer         <= '0;
      ref_q         <= '0;
    end else begin
      ber_clear     <= 1'b0;
      done          <= 1'b0;
      bus.cmp_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            if (num_frames != 16'd0) begin
              frames_lat <= num_frames;
              busy       <= 1'b1;
              ber_clear  <= 1'b1;
              state      <= CLEAR;
            end else begin
              done <= 1'b1;
            end
          end
        end

        CLEAR: begin
          timeouts     <= '0;
          frame_cnt    <= '0;
          bus.tx_data  <= tx_word;
          bus.tx_valid <= 1'b1;
          state        <= SEND;
        end

        SEND: begin
          if (bus.tx_ready) begin
            ref_q        <= lfsr_word;
            bus.tx_valid <= 1'b0;
            timer        <= '0;
            state        <= WAIT_RX;
          end
        end

        WAIT_RX: begin
          // A receive on the last timeout cycle still counts as a receive.
          if (bus.rx_valid || timer_hit) begin
            if (bus.rx_valid) begin
              bus.cmp_valid <= 1'b1;
              bus.cmp_tx    <= ref_q;
              bus.cmp_rx    <= bus.rx_data;
            end else if (timeouts != 16'hFFFF) begin
              timeouts <= timeouts + 16'd1;
            end
            frame_cnt <= frame_cnt_nxt;
            if (frame_cnt_nxt == frames_lat) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              bus.tx_data  <= tx_word;
              bus.tx_valid <= 1'b1;
              state        <= SEND;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ber_test_ctrl.sv
// Scoreboard bench for ber_test_ctrl: a channel model echoes frames, a monitor
// pops expected compare pairs whenever cmp_valid is seen.
`timescale 1ns/1ps
module tb_ber_test_ctrl;
  import ber_pkg::*;

  localparam int DATA_W      = 16;
  localparam int TIMEOUT_CYC = 255;
  localparam int NTBL        = 5;
`ifdef BER_CTRL_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_frames = '0;
  logic        ber_clear, busy, done;
  logic [15:0] timeouts;

  ber_test_ctrl_if #(.DATA_W(DATA_W)) bus ();

  ber_test_ctrl #(
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_frames (num_frames),
    .bus        (bus),
    .ber_clear  (ber_clear),
    .busy       (busy),
    .done       (done),
    .timeouts   (timeouts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] tx;
    logic [15:0] rx;
    logic [15:0] x;
    bit          full;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] prbs_tbl [NTBL] = '{16'hACE1, 16'h5670, 16'hAB38, 16'h559C, 16'h2ACE};

  // Channel model controls: per-frame echo delay (cycles into WAIT_RX) and
  // number of cycles tx_ready is held low on the first frame.
  int ch_delay [16];
  int ch_stall   = 0;
  int ch_idx     = 0;
  int pend_wait  = 0;
  bit pend_push  = 1'b0;
  exp_t pend_exp;
  int valid_cyc0 = 0;

  int cmp_cnt = 0, done_cnt = 0, clr_cnt = 0, cmp_at_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] inj_expect(input int idx);
    return (INJ && (idx % 8 == 7)) ? 16'h0001 : 16'h0000;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [15:0] nf);
    step();
    start      = 1'b1;
    num_frames = nf;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      step();
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
    step();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tx_valid"},  bus.tx_valid,  1'b0);
    check({tag, "_tx_data"},   bus.tx_data,   16'h0);
    check({tag, "_cmp_valid"}, bus.cmp_valid, 1'b0);
    check({tag, "_cmp_tx"},    bus.cmp_tx,    16'h0);
    check({tag, "_cmp_rx"},    bus.cmp_rx,    16'h0);
    check({tag, "_ber_clear"}, ber_clear,     1'b0);
    check({tag, "_done"},      done,          1'b0);
    check({tag, "_busy"},      busy,          1'b0);
    check({tag, "_timeouts"},  timeouts,      16'h0);
  endtask

  // Channel: owns tx_ready/rx_valid/rx_data, echoes each accepted frame.
  initial begin
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    forever begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      if (reset || ber_clear) begin
        pend_wait  = 0;
        ch_idx     = 0;
        valid_cyc0 = 0;
        bus.tx_ready = 1'b0;
      end else begin
        if (pend_wait > 0) begin
          pend_wait--;
          if (pend_wait == 0) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = pend_exp.rx;
            if (pend_push) sb.push_back(pend_exp);
          end
        end
        if (bus.tx_valid) begin
          if (ch_idx == 0) valid_cyc0++;
          if (ch_idx < NTBL) check("tx_data", bus.tx_data, prbs_tbl[ch_idx]);
          if (ch_stall > 0) begin
            bus.tx_ready = 1'b0;
            ch_stall--;
          end else begin
            bus.tx_ready  = 1'b1;
            pend_exp.full = (ch_idx < NTBL);
            pend_exp.tx   = (ch_idx < NTBL) ? prbs_tbl[ch_idx] : 16'h0;
            pend_exp.x    = inj_expect(ch_idx);
            pend_exp.rx   = bus.tx_data;
            pend_wait     = ch_delay[ch_idx % 16];
            pend_push     = (pend_wait > 0) && (pend_wait <= TIMEOUT_CYC);
            ch_idx++;
          end
        end else begin
          bus.tx_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each compare pair, counts pulses.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.cmp_valid) begin
          cmp_cnt++;
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmp_unexpected: got pair tx=%h rx=%h, expected no pair", bus.cmp_tx, bus.cmp_rx);
          end else begin
            e = sb.pop_front();
            if (e.full) check("cmp_tx", bus.cmp_tx, e.tx);
            check("cmp_rx", bus.cmp_rx, e.rx);
            check("cmp_xor", bus.cmp_tx ^ bus.cmp_rx, e.x);
          end
        end
        if (done) begin
          done_cnt++;
          cmp_at_done = cmp_cnt;
        end
        if (ber_clear) clr_cnt++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d0, k0;
    for (int i = 0; i < 16; i++) ch_delay[i] = 1;

    // Reset state
    step(3);
    check_idle_outputs("reset");
    reset = 1'b0;
    step(2);

    // Loopback, 4 frames, with an ignored start mid-run
    c0 = cmp_cnt; d0 = done_cnt; k0 = clr_cnt;
    pulse_start(16'd4);
    step(2);
    check("busy_in_run", busy, 1'b1);
    start = 1'b1; num_frames = 16'd9;
    step();
    start = 1'b0; num_frames = 16'd4;
    wait_done("loop_done", 100);
    check("loop_cmp_cnt", cmp_cnt - c0, 4);
    check("loop_cmp_at_done", cmp_at_done - c0, 4);
    check("loop_done_cnt", done_cnt - d0, 1);
    check("loop_clear_cnt", clr_cnt - k0, 1);
    check("loop_timeouts", timeouts, 16'h0);
    check("loop_busy_after", busy, 1'b0);
    check("loop_sb_empty", sb.size(), 0);

    // Backpressure: tx_ready low for 5 cycles on the first frame
    c0 = cmp_cnt; d0 = done_cnt;
    ch_stall = 5;
    pulse_start(16'd1);
    wait_done("bp_done", 100);
    check("bp_valid_cycles", valid_cyc0, 6);
    check("bp_cmp_cnt", cmp_cnt - c0, 1);
    check("bp_done_cnt", done_cnt - d0, 1);

    // Lost frame: frame 0 echoed one cycle too late (lands in SEND, ignored)
    c0 = cmp_cnt; d0 = done_cnt;
    ch_delay[0] = TIMEOUT_CYC + 1;
    pulse_start(16'd2);
    wait_done("lost_done", 3 * TIMEOUT_CYC);
    check("lost_timeouts", timeouts, 16'd1);
    check("lost_cmp_cnt", cmp_cnt - c0, 1);
    check("lost_done_cnt", done_cnt - d0, 1);
    check("lost_sb_empty", sb.size(), 0);

    // Echo on the exact timeout cycle counts as a receive
    c0 = cmp_cnt;
    ch_delay[0] = TIMEOUT_CYC;
    pulse_start(16'd1);
    wait_done("edge_done", 3 * TIMEOUT_CYC);
    check("edge_cmp_cnt", cmp_cnt - c0, 1);
    check("edge_timeouts", timeouts, 16'h0);
    ch_delay[0] = 1;

    // Start with zero frames: done next cycle, never busy
    d0 = done_cnt; k0 = clr_cnt;
    pulse_start(16'd0);
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    step();
    check("zero_done_off", done, 1'b0);
    check("zero_busy_after", busy, 1'b0);
    check("zero_clear_cnt", clr_cnt - k0, 0);

    // Reset while waiting for an echo aborts silently
    ch_delay[0] = 100;
    pulse_start(16'd3);
    step(6);
    check("rst_busy_before", busy, 1'b1);
    d0 = done_cnt;
    reset = 1'b1;
    step();
    check_idle_outputs("rst_mid");
    reset = 1'b0;
    step(5);
    check("rst_no_done", done_cnt - d0, 0);
    ch_delay[0] = 1;

    // Normal run after the abort
    c0 = cmp_cnt; d0 = done_cnt;
    pulse_start(16'd2);
    wait_done("rerun_done", 100);
    check("rerun_cmp_cnt", cmp_cnt - c0, 2);
    check("rerun_done_cnt", done_cnt - d0, 1);
    check("rerun_timeouts", timeouts, 16'h0);
    check("rerun_sb_empty", sb.size(), 0);

`ifdef BER_CTRL_INJECT_EN
    // 16-frame loopback: only frames 7 and 15 differ, in bit 0
    c0 = cmp_cnt;
    pulse_start(16'd16);
    wait_done("inj_done", 300);
    check("inj_cmp_cnt", cmp_cnt - c0, 16);
    check("inj_sb_empty", sb.size(), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ber_test_ctrl.md
BER_TEST_CTRL -- requirements
Module: ber_test_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, frame word width.
REQ-002 Parameter TIMEOUT_CYC, default 255, max cycles WAIT_RX waits for rx_valid.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, PRBS seed; must be non-zero.
REQ-004 Ports SHALL be exactly as follows. One clock; reset is synchronous and active-high.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a test run.
- num_frames  in  16  frames per run; sampled on start.
- tx_ready  in  1  channel accepts tx_data.
- tx_valid  out  1  tx_data valid.
- tx_data  out  DATA_W  PRBS frame to channel.
- rx_valid  in  1  received frame valid.
- rx_data  in  DATA_W  received frame.
- cmp_valid  out  1  aligned pair valid for the BER calculator.
- cmp_tx  out  DATA_W  reference frame.
- cmp_rx  out  DATA_W  received frame.
- ber_clear  out  1  one-cycle clear pulse to the BER calculator.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- timeouts  out  16  frames lost to timeout in the current run.

Function
REQ-005 FSM states SHALL be IDLE, CLEAR, SEND, WAIT_RX and FINISH.
REQ-006 IDLE: on start=1 with num_frames!=0, latch num_frames, reload LFSR with LFSR_SEED, and go to CLEAR; start with num_frames==0 SHALL pulse done next cycle and remain in IDLE.
REQ-007 CLEAR: assert ber_clear for exactly one cycle, zero timeouts and the frame counter, then go to SEND.
REQ-008 SEND: hold tx_valid=1 and tx_data stable until tx_ready=1; on handshake, store tx_data as reference, advance LFSR (x^16+x^14+x^13+x^11+1, Fibonacci), go to WAIT_RX.
REQ-009 WAIT_RX: on rx_valid=1, drive cmp_valid=1 with cmp_tx=reference and cmp_rx=rx_data on the next cycle (1-cycle registered latency), increment frame counter.
REQ-010 WAIT_RX timeout: if rx_valid has not arrived after TIMEOUT_CYC cycles, increment timeouts (saturating at 16'hFFFF), do not assert cmp_valid, and count the frame as sent.
REQ-011 After a frame completes: if frame counter==latched num_frames go to FINISH, else go to SEND.
REQ-012 FINISH: pulse done for one cycle, return to IDLE.
REQ-013 rx_valid outside WAIT_RX SHALL be ignored; it SHALL NOT produce cmp_valid.
REQ-014 rx_valid in the same cycle the timeout expires SHALL be treated as a valid receive, not a timeout.
REQ-015 start while busy=1 SHALL be ignored.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 cmp_tx and cmp_rx SHALL hold their last values while cmp_valid=0.

Reset
REQ-018 On reset=1 at a clk edge: state=IDLE; tx_valid, cmp_valid, ber_clear, done and busy=0; tx_data, cmp_tx, cmp_rx and timeouts=0; LFSR=LFSR_SEED.
REQ-019 Reset mid-run SHALL abort the run immediately with no done pulse.

Configuration
REQ-020 With BER_CTRL_INJECT_EN defined, every 8th transmitted frame (frame index 7, 15, …) SHALL have bit 0 of tx_data inverted; cmp_tx carries the uninjected reference.
REQ-021 Without BER_CTRL_INJECT_EN, tx_data SHALL equal the LFSR value exactly, and no inject logic SHALL be synthesized.

Structure
REQ-022 Package ber_pkg SHALL hold the FSM state enum, the LFSR tap constant and the default seed.
REQ-023 LFSR SHALL be a sub-module prbs16 with enable and load inputs; all other logic stays in ber_test_ctrl.

Verification
REQ-024 Loopback: num_frames=4, tx_ready=1, rx echoes tx one cycle later -> 4 cmp_valid with cmp_tx==cmp_rx, one ber_clear, done after 4th pair, timeouts=0.
REQ-025 Backpressure: tx_ready held low 5 cycles -> tx_valid and tx_data stable throughout; handshake on 6th cycle; first tx_data=16'hACE1.
REQ-026 Lost frame: num_frames=2, no rx for frame 1 -> timeouts=1 after TIMEOUT_CYC cycles, single cmp_valid, done asserted.
REQ-027 Edge cases: rx_valid on exact timeout cycle -> cmp_valid, timeouts unchanged; start with num_frames=0 -> done next cycle, busy stays 0.
REQ-028 Reset in WAIT_RX -> all outputs 0 next cycle, no done; new start works normally.
REQ-029 With BER_CTRL_INJECT_EN, num_frames=16, loopback -> cmp_tx^cmp_rx==16'h0001 on frames 7 and 15 only.
